// File: rtl/alu_rs_if.sv
// Issue, CDB and ALU-dispatch bundle of the ALU reservation station.
// "slave" is the reservation station side; "master" is the core/decoder side.
interface alu_rs_if #(
    parameter int ROB_SIZE_BIT = 4,
    parameter int RS_TYPE_BIT  = 4
);
    logic                    iss_valid;
    logic [RS_TYPE_BIT-1:0]  iss_type;
    logic [31:0]             iss_r1_val;
    logic                    iss_r1_dep;
    logic [ROB_SIZE_BIT-1:0] iss_r1_rob;
    logic [31:0]             iss_r2_val;
    logic                    iss_r2_dep;
    logic [ROB_SIZE_BIT-1:0] iss_r2_rob;
    logic [ROB_SIZE_BIT-1:0] iss_rob_id;
    logic                    rs_full;

    logic                    cdb_valid;
    logic [ROB_SIZE_BIT-1:0] cdb_rob_id;
    logic [31:0]             cdb_val;

    logic                    alu_input;
    logic [RS_TYPE_BIT-1:0]  arith_type;
    logic [31:0]             r1_val;
    logic [31:0]             r2_val;
    logic [ROB_SIZE_BIT-1:0] inst_rob_id;

    modport master (
        output iss_valid, iss_type, iss_r1_val, iss_r1_dep, iss_r1_rob,
               iss_r2_val, iss_r2_dep, iss_r2_rob, iss_rob_id,
               cdb_valid, cdb_rob_id, cdb_val,
        input  rs_full, alu_input, arith_type, r1_val, r2_val, inst_rob_id
    );

    modport slave (
        input  iss_valid, iss_type, iss_r1_val, iss_r1_dep, iss_r1_rob,
               iss_r2_val, iss_r2_dep, iss_r2_rob, iss_rob_id,
               cdb_valid, cdb_rob_id, cdb_val,
        output rs_full, alu_input, arith_type, r1_val, r2_val, inst_rob_id
    );
endinterface

// File: rtl/alu_rs.sv
// Reservation station for the single-cycle ALU: buffers issued instructions,
// wakes operands from the CDB and dispatches the lowest-index ready entry per cycle.
module alu_rs #(
    parameter int RS_SIZE      = 8,
    parameter int RS_SIZE_BIT  = 3,
    parameter int ROB_SIZE_BIT = 4,
    parameter int RS_TYPE_BIT  = 4
) (
    input logic     clk_in,
    input logic     rst_in,
    input logic     rdy_in,
    input logic     clear_in,
    alu_rs_if.slave bus
);

    typedef struct packed {
        logic [RS_TYPE_BIT-1:0]  op;
        logic [ROB_SIZE_BIT-1:0] rob;
        logic [31:0]             v1;
        logic                    d1;
        logic [ROB_SIZE_BIT-1:0] s1;
        logic [31:0]             v2;
        logic                    d2;
        logic [ROB_SIZE_BIT-1:0] s2;
    } entry_t;

    logic [RS_SIZE-1:0]     busy;
    logic [RS_SIZE-1:0]     busy_next;
    entry_t                 ent [RS_SIZE];
    logic [RS_SIZE_BIT-1:0] free_idx;
    logic [RS_SIZE_BIT-1:0] disp_idx;
    logic                   has_ready;
    logic                   do_issue;
    logic                   fwd1;
    logic                   fwd2;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        free_idx  = '0;
        disp_idx  = '0;
        has_ready = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = RS_SIZE_BIT'(i);
            if (busy[i] && !ent[i].d1 && !ent[i].d2) begin
                disp_idx  = RS_SIZE_BIT'(i);
                has_ready = 1'b1;
            end
        end
    end

    assign bus.rs_full = &busy;
    assign do_issue    = bus.iss_valid && !bus.rs_full;
    assign fwd1 = bus.iss_r1_dep && bus.cdb_valid && (bus.cdb_rob_id == bus.iss_r1_rob);
    assign fwd2 = bus.iss_r2_dep && bus.cdb_valid && (bus.cdb_rob_id == bus.iss_r2_rob);

    // The issue slot is free in registered state, so it never collides with the dispatch slot.
    always_comb begin
        busy_next = busy;
        if (has_ready) busy_next[disp_idx] = 1'b0;
        if (do_issue)  busy_next[free_idx] = 1'b1;
    end

    // NOTE: entry payloads are qualified by busy, so they need no reset and stay plain RAM-like flops.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !clear_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (do_issue && free_idx == RS_SIZE_BIT'(i)) begin
                    ent[i] <= '{op: bus.iss_type, rob: bus.iss_rob_id,
                                v1: fwd1 ? bus.cdb_val : bus.iss_r1_val,
                                d1: bus.iss_r1_dep && !fwd1, s1: bus.iss_r1_rob,
                                v2: fwd2 ? bus.cdb_val : bus.iss_r2_val,
                                d2: bus.iss_r2_dep && !fwd2, s2: bus.iss_r2_rob};
                end else if (bus.cdb_valid) begin
                    if (ent[i].d1 && ent[i].s1 == bus.cdb_rob_id) begin
                        ent[i].v1 <= bus.cdb_val;
                        ent[i].d1 <= 1'b0;
                    end
                    if (ent[i].d2 && ent[i].s2 == bus.cdb_rob_id) begin
                        ent[i].v2 <= bus.cdb_val;
                        ent[i].d2 <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy            <= '0;
            bus.alu_input   <= 1'b0;
            bus.arith_type  <= '0;
            bus.r1_val      <= '0;
            bus.r2_val      <= '0;
            bus.inst_rob_id <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                busy          <= '0;
                bus.alu_input <= 1'b0;
            end else begin
                busy          <= busy_next;
                bus.alu_input <= has_ready;
                if (has_ready) begin
                    bus.arith_type  <= ent[disp_idx].op;
                    bus.r1_val      <= ent[disp_idx].v1;
                    bus.r2_val      <= ent[disp_idx].v2;
                    bus.inst_rob_id <= ent[disp_idx].rob;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus a randomized phase,
// compared every cycle against a queue-based behavioural model.
module tb_alu_rs;
    localparam int ROB_W  = 4;
    localparam int TYPE_W = 4;
    localparam int N      = 8;

    logic clk_in   = 1'b0;
    logic rst_in   = 1'b0;
    logic rdy_in   = 1'b1;
    logic clear_in = 1'b0;

    alu_rs_if #(.ROB_SIZE_BIT(ROB_W), .RS_TYPE_BIT(TYPE_W)) bus ();

    alu_rs #(.RS_SIZE(N), .RS_SIZE_BIT(3), .ROB_SIZE_BIT(ROB_W), .RS_TYPE_BIT(TYPE_W)) dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rdy_in  (rdy_in),
        .clear_in(clear_in),
        .bus     (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          slot;
        logic [3:0]  op;
        logic [3:0]  rob;
        logic [31:0] v1;
        bit          d1;
        logic [3:0]  s1;
        logic [31:0] v2;
        bit          d2;
        logic [3:0]  s2;
    } pend_t;

    pend_t       q[$];
    logic        e_alu;
    logic [3:0]  e_type;
    logic [3:0]  e_rob;
    logic [31:0] e_r1;
    logic [31:0] e_r2;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".alu_input"},   {31'd0, bus.alu_input}, {31'd0, e_alu});
        check({tag, ".rs_full"},     {31'd0, bus.rs_full},   {31'd0, q.size() == N});
        check({tag, ".arith_type"},  {28'd0, bus.arith_type}, {28'd0, e_type});
        check({tag, ".r1_val"},      bus.r1_val, e_r1);
        check({tag, ".r2_val"},      bus.r2_val, e_r2);
        check({tag, ".inst_rob_id"}, {28'd0, bus.inst_rob_id}, {28'd0, e_rob});
    endtask

    task automatic reset_model();
        q.delete();
        e_alu = 1'b0; e_type = '0; e_rob = '0; e_r1 = '0; e_r2 = '0;
    endtask

    // One clock edge of the reservation station as seen from outside.
    task automatic model_step();
        int    k;
        int    slot;
        bit    used[N];
        bit    take;
        pend_t nw;
        if (!rdy_in) return;
        if (clear_in) begin
            q.delete();
            e_alu = 1'b0;
            return;
        end
        k = -1;
        foreach (q[i])
            if (!q[i].d1 && !q[i].d2 && (k < 0 || q[i].slot < q[k].slot)) k = i;
        e_alu = (k >= 0);
        if (k >= 0) begin
            e_type = q[k].op; e_rob = q[k].rob; e_r1 = q[k].v1; e_r2 = q[k].v2;
        end
        take = bus.iss_valid && (q.size() < N);
        if (take) begin
            for (int s = 0; s < N; s++) used[s] = 1'b0;
            foreach (q[i]) used[q[i].slot] = 1'b1;
            slot = -1;
            for (int s = N - 1; s >= 0; s--) if (!used[s]) slot = s;
            nw.slot = slot; nw.op = bus.iss_type; nw.rob = bus.iss_rob_id;
            nw.s1 = bus.iss_r1_rob; nw.s2 = bus.iss_r2_rob;
            nw.d1 = bus.iss_r1_dep; nw.v1 = bus.iss_r1_val;
            nw.d2 = bus.iss_r2_dep; nw.v2 = bus.iss_r2_val;
            if (bus.cdb_valid && nw.d1 && nw.s1 == bus.cdb_rob_id) begin nw.v1 = bus.cdb_val; nw.d1 = 0; end
            if (bus.cdb_valid && nw.d2 && nw.s2 == bus.cdb_rob_id) begin nw.v2 = bus.cdb_val; nw.d2 = 0; end
        end
        if (bus.cdb_valid) begin
            foreach (q[i]) begin
                if (q[i].d1 && q[i].s1 == bus.cdb_rob_id) begin q[i].v1 = bus.cdb_val; q[i].d1 = 0; end
                if (q[i].d2 && q[i].s2 == bus.cdb_rob_id) begin q[i].v2 = bus.cdb_val; q[i].d2 = 0; end
            end
        end
        if (k >= 0) q.delete(k);
        if (take) q.push_back(nw);
    endtask

    task automatic tick(input string tag);
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
        compare_all(tag);
    endtask

    task automatic idle();
        bus.iss_valid = 1'b0;
        bus.cdb_valid = 1'b0;
        clear_in      = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op,
                         input logic [31:0] v1, input logic d1, input logic [3:0] s1,
                         input logic [31:0] v2, input logic d2, input logic [3:0] s2,
                         input logic [3:0] rob);
        bus.iss_valid  = 1'b1;
        bus.iss_type   = op;
        bus.iss_r1_val = v1; bus.iss_r1_dep = d1; bus.iss_r1_rob = s1;
        bus.iss_r2_val = v2; bus.iss_r2_dep = d2; bus.iss_r2_rob = s2;
        bus.iss_rob_id = rob;
    endtask

    task automatic cdb(input logic [3:0] rob, input logic [31:0] val);
        bus.cdb_valid  = 1'b1;
        bus.cdb_rob_id = rob;
        bus.cdb_val    = val;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        issue(0, 0, 0, 0, 0, 0, 0, 0);
        cdb(0, 0);
        idle();
        reset_model();
        #1 compare_all("reset");
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;

        // Ready instruction: dispatched after the next edge, strobe lasts one cycle.
        issue(1, 5, 0, 0, 7, 0, 0, 2);
        tick("add_issue");
        idle();
        tick("add_disp");
        tick("add_drop");

        // Operand 1 waits on ROB 3, broadcast two cycles later.
        issue(2, 0, 1, 3, 9, 0, 0, 4);
        tick("dep_issue");
        idle();
        tick("dep_wait");
        cdb(3, 32'h10);
        tick("dep_wake");
        idle();
        tick("dep_disp");
        tick("dep_drop");

        // Same-cycle CDB forwarding into the issued entry.
        issue(3, 0, 1, 6, 1, 0, 0, 5);
        cdb(6, 32'hAB);
        tick("fwd_issue");
        idle();
        tick("fwd_disp");
        tick("fwd_drop");

        // Fill all entries on ROB 9, then drain in index order.
        for (int i = 0; i < N; i++) begin
            issue(4, 32'(i), 1, 9, 32'(100 + i), 0, 0, 4'(i));
            tick("fill");
        end
        idle();
        cdb(9, 32'h55);
        tick("fill_bcast");
        idle();
        for (int i = 0; i < N + 1; i++) tick("drain");

        // Two ready entries flushed by clear; the concurrent issue is dropped.
        issue(5, 0, 1, 11, 0, 1, 11, 12);
        tick("clr_iss0");
        issue(6, 0, 1, 11, 3, 0, 0, 13);
        tick("clr_iss1");
        idle();
        cdb(11, 32'h77);
        tick("clr_wake");
        idle();
        clear_in = 1'b1;
        issue(7, 1, 0, 0, 2, 0, 0, 14);
        tick("clear");
        idle();
        tick("post_clear0");
        tick("post_clear1");

        // rdy_in low freezes outputs and state; stimulus during the freeze is ignored.
        issue(8, 1, 0, 0, 2, 0, 0, 1);
        tick("frz_iss0");
        issue(9, 3, 0, 0, 4, 0, 0, 2);
        tick("frz_iss1");
        rdy_in = 1'b0;
        issue(10, 6, 0, 0, 6, 0, 0, 3);
        cdb(2, 32'hDEAD);
        for (int i = 0; i < 3; i++) tick("frozen");
        idle();
        rdy_in = 1'b1;
        tick("resume");
        tick("resume_drop");

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            idle();
            rdy_in   = ($urandom_range(0, 9) != 0);
            clear_in = ($urandom_range(0, 49) == 0);
            if (q.size() < N && $urandom_range(0, 2) != 0)
                issue(4'($urandom_range(0, 15)),
                      $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                      $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                      4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) != 0) cdb(4'($urandom_range(0, 7)), $urandom);
            tick("rand");
        end

        // Asynchronous reset between edges with a dispatch in flight.
        idle();
        rdy_in = 1'b1;
        clear_in = 1'b1;
        tick("pre_rst_clear");
        idle();
        issue(11, 32'h21, 0, 0, 32'h22, 0, 0, 6);
        tick("pre_rst0");
        issue(12, 32'h31, 0, 0, 32'h32, 0, 0, 7);
        tick("pre_rst1");
        idle();
        #2 rst_in = 1'b0;
        #1 reset_model();
        compare_all("async_rst");
        @(negedge clk_in);
        compare_all("rst_hold");
        rst_in = 1'b1;
        issue(13, 32'h41, 0, 0, 32'h42, 0, 0, 8);
        tick("post_rst_iss");
        idle();
        tick("post_rst_disp");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
